branch_pred_gshare: RTL and testbench
=====================================

# branch_pred_gshare

Parametrised successor to the single-counter branch predictor. It holds a table of 2-bit saturating counters, indexed by PC bits XORed with a global branch history register (gshare); with `GHR_BITS=0` it degenerates to a bimodal predictor. It sits in the fetch stage next to the pre-decoder. It produces a same-cycle taken prediction and target, and it accepts resolved outcomes from EX to train counters and repair the history after a mispredict.

## Interface
- `IDX_BITS`, 6: table has 2^IDX_BITS counters.
- `GHR_BITS`, 4: global history length. Legal range 0..IDX_BITS; 0 = bimodal.
- `PC_LSB`, 0: lowest PC bit used for indexing.
- `CTR_INIT`, 2'd2: counter reset value (weak taken).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc_1`  in  32  PC of the instruction being fetched.
- `branch`  in  1  pre-decoder: the instruction is a conditional branch.
- `offset`  in  16  branch offset, sign-extended for target.
- `pred_taken`  out  1  predicted taken; gated by `branch`.
- `pred_addr`  out  32  `pc_1` + sign-extended `offset`, mod 2^32.
- `pred_idx`  out  IDX_BITS  table index used this cycle; piped to EX.
- `pred_ghr`  out  max(GHR_BITS,1)  GHR value before this prediction's shift; piped to EX.
- `upd_valid`  in  1  EX resolved a branch this cycle.
- `upd_taken`  in  1  actual outcome of the resolved branch.
- `upd_idx`  in  IDX_BITS  `pred_idx` carried with that branch.
- `upd_ghr`  in  max(GHR_BITS,1)  `pred_ghr` carried with that branch.
- `upd_mispredict`  in  1  predicted direction was wrong; only meaningful with `upd_valid`.

## Operation
- Counter encoding: 0 strong NT, 1 weak NT, 2 weak T, 3 strong T. Prediction is counter bit 1.
- Index = `pc_1[PC_LSB+IDX_BITS-1:PC_LSB]` XOR zero-extended `ghr`. When GHR_BITS=0 there is no XOR, and `pred_ghr` is tied to 0.
- `pred_taken` = `branch` AND `ctr[index][1]`. `pred_addr` is computed regardless of `branch`.
- Training: when `upd_valid` is high, `ctr[upd_idx]` increments if `upd_taken`, otherwise decrements. The counter saturates at 3 and 0.
- Speculative history: when `branch` is high and no recovery occurs that cycle, `ghr <= {ghr[GHR_BITS-2:0], pred_taken}`. For GHR_BITS=1, `ghr <= pred_taken`.
- Recovery: when `upd_valid && upd_mispredict`, `ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}`.
- Recovery has priority over the speculative shift in the same cycle. The fetch-side prediction is still output that cycle but leaves no history trace.
- `upd_mispredict` without `upd_valid` is ignored.
- Read and write to the same index in the same cycle: the read returns the old counter value. There is no bypass.
- Reset: every counter = CTR_INIT and `ghr` = 0. Outputs are then `pred_taken` = `branch` & CTR_INIT[1], `pred_idx` = PC bits, and `pred_ghr` = 0.
- Reset asserted mid-operation clears state immediately, independent of `clk`. Updates in flight are lost.

## Timing
- Prediction path is combinational: `pc_1`, `branch`, `offset` → `pred_*` in the same cycle.
- Counter and GHR updates are visible on the cycle after the edge that captures them.
- Latency from a training event to the changed prediction is 1 cycle.
- No handshake. The block accepts one prediction and one update every cycle.

## Test plan
- Reset with `pc_1`=0x100, `branch`=1, then release reset → `pred_taken`=1, `pred_ghr`=0, and `pred_addr` = `pc_1`+offset. Check `offset`=0xFFFC gives 0x0FC.
- Bimodal (GHR_BITS=0), idx 5:
  - 2 not-taken updates → predicts NT.
  - 2 more not-taken → counter stays 0.
  - 2 taken → predicts T.
  - 3 more taken → counter saturates at 3.
  - 1 not-taken → still T.
- Gshare, GHR_BITS=4:
  - 3 predicted-taken branches from reset → `ghr`=4'b0111.
  - `pred_idx` for PC index 6'h0A becomes 6'h0A^6'h07 = 6'h0D.
- Mispredict recovery, same cycle as `branch`=1:
  - Drive `upd_ghr`=4'b1010, `upd_taken`=0 → next `ghr`=4'b0100.
  - The speculative shift is discarded.
- Same-index read/write: update idx 3 taken while fetching idx 3 from counter=1 → same-cycle `pred_taken`=0, next cycle 1.
- Assert `rst` asynchronously mid-stream after training → counters and `ghr` restore immediately without a clock edge.

Source files
------------

// File: rtl/branch_pred_gshare.sv
// ---------------------------------------------------------------------------
// branch_pred_gshare
//
// Fetch-stage conditional branch predictor. A table of 2^IDX_BITS two-bit
// saturating counters is indexed by PC bits XORed with a global history
// register (gshare). With GHR_BITS = 0 the history disappears and the table
// is indexed by PC bits alone (bimodal).
//
// The prediction path is purely combinational: the instruction being fetched
// gets its direction, target and the bookkeeping values (index, history
// snapshot) in the same cycle. EX returns those bookkeeping values with the
// resolved outcome so the right counter is trained and, on a mispredict, the
// history is rebuilt from the snapshot plus the real outcome.
//
// Ports
//   clk            clock, all state changes on its rising edge
//   rst            asynchronous active-high reset
//   pc_1           PC of the instruction being fetched
//   branch         pre-decoder flag: instruction is a conditional branch
//   offset         branch offset, sign-extended to form the target
//   pred_taken     predicted taken (forced low when branch = 0)
//   pred_addr      pc_1 + sign-extended offset, modulo 2^32
//   pred_idx       counter index used this cycle (carried to EX)
//   pred_ghr       history before this prediction's shift (carried to EX)
//   upd_valid      EX resolved a branch this cycle
//   upd_taken      resolved direction
//   upd_idx        pred_idx that travelled with the resolved branch
//   upd_ghr        pred_ghr that travelled with the resolved branch
//   upd_mispredict resolved direction differs from the prediction
//
// Parameters
//   IDX_BITS  log2 of the counter table size
//   GHR_BITS  history length, 0..IDX_BITS (0 = bimodal)
//   PC_LSB    lowest PC bit used to form the index
//   CTR_INIT  counter value after reset
// ---------------------------------------------------------------------------
module branch_pred_gshare #(
    parameter int         IDX_BITS = 6,
    parameter int         GHR_BITS = 4,
    parameter int         PC_LSB   = 0,
    parameter logic [1:0] CTR_INIT = 2'd2,
    localparam int        GW       = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_1,
    input  logic                branch,
    input  logic [15:0]         offset,
    output logic                pred_taken,
    output logic [31:0]         pred_addr,
    output logic [IDX_BITS-1:0] pred_idx,
    output logic [GW-1:0]       pred_ghr,
    input  logic                upd_valid,
    input  logic                upd_taken,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic [GW-1:0]       upd_ghr,
    input  logic                upd_mispredict
);

    localparam int N_CTR = 1 << IDX_BITS;

    logic [IDX_BITS-1:0] pc_idx;
    logic [IDX_BITS-1:0] rd_idx;
    logic [GW-1:0]       ghr_reg;
    logic [1:0]          ctr_val [N_CTR];
    logic                pred_dir;

    // -----------------------------------------------------------------------
    // Prediction path (combinational)
    // -----------------------------------------------------------------------
    assign pc_idx     = pc_1[PC_LSB +: IDX_BITS];

    // Counter MSB is the direction. The table is read before any same-cycle
    // training lands, so a colliding update is seen only from the next cycle.
    assign pred_dir   = ctr_val[rd_idx][1];
    assign pred_taken = branch & pred_dir;

    // Target is produced for every fetch; the consumer qualifies it.
    assign pred_addr  = pc_1 + {{16{offset[15]}}, offset};

    assign pred_idx   = rd_idx;
    assign pred_ghr   = ghr_reg;

    // -----------------------------------------------------------------------
    // Counter table
    //
    // Each counter is its own register so the whole table clears on the
    // asynchronous reset. Only the entry addressed by upd_idx moves.
    // -----------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < N_CTR; gi++) begin : g_ctr
        logic [1:0] ctr_reg;
        logic [1:0] ctr_next;
        logic       hit;

        assign hit = upd_valid && (upd_idx == IDX_BITS'(gi));

        // Saturating step: taken counts up towards 3, not-taken down to 0.
        always_comb begin
            ctr_next = ctr_reg;
            if (hit) begin
                if (upd_taken) begin
                    if (ctr_reg != 2'd3) begin
                        ctr_next = ctr_reg + 2'd1;
                    end
                end else begin
                    if (ctr_reg != 2'd0) begin
                        ctr_next = ctr_reg - 2'd1;
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ctr_reg <= CTR_INIT;
            end else begin
                ctr_reg <= ctr_next;
            end
        end

        assign ctr_val[gi] = ctr_reg;
    end

    // -----------------------------------------------------------------------
    // Global history
    // -----------------------------------------------------------------------
    if (GHR_BITS == 0) begin : g_bimodal
        // No history: index straight from the PC, snapshot reads as zero.
        // The repair inputs have nothing to act on in this configuration.
        logic unused_repair;

        assign ghr_reg       = '0;
        assign rd_idx        = pc_idx;
        assign unused_repair = ^{upd_ghr, upd_mispredict};
    end else begin : g_gshare
        logic [GW-1:0] ghr_next;
        logic          recover;

        // History occupies the low index bits; upper bits see PC only.
        assign rd_idx  = pc_idx ^ IDX_BITS'(ghr_reg);

        // A mispredict in EX wins over the fetch-side speculative shift:
        // the branch being fetched this cycle is on the wrong path anyway,
        // so its guess must not leave a trace in the history.
        assign recover = upd_valid & upd_mispredict;

        if (GHR_BITS == 1) begin : g_len1
            // A one-bit history only remembers the latest outcome, so the
            // snapshot carried back from EX carries no useful information.
            logic unused_snapshot;

            assign unused_snapshot = ^upd_ghr;

            always_comb begin
                ghr_next = ghr_reg;
                if (recover) begin
                    ghr_next = upd_taken;
                end else if (branch) begin
                    ghr_next = pred_taken;
                end
            end
        end else begin : g_lenn
            // The oldest snapshot bit is shifted out during repair.
            logic unused_snapshot_msb;

            assign unused_snapshot_msb = upd_ghr[GHR_BITS-1];

            always_comb begin
                ghr_next = ghr_reg;
                if (recover) begin
                    ghr_next = {upd_ghr[GHR_BITS-2:0], upd_taken};
                end else if (branch) begin
                    ghr_next = {ghr_reg[GHR_BITS-2:0], pred_taken};
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ghr_reg <= '0;
            end else begin
                ghr_reg <= ghr_next;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_gshare.sv
// ---------------------------------------------------------------------------
// tb_branch_pred_gshare
//
// Two instances: a gshare predictor (GHR_BITS = 4) and a bimodal one
// (GHR_BITS = 0). A behavioural model keeps every counter as a plain integer
// 0..3 and the history as the integer formed by the last four outcomes; it
// advances on each clock edge and clears on reset, independently of the DUT.
// Inputs change 1 ns after the rising edge; outputs are compared on the
// falling edge (or 1 ns after an asynchronous reset).
// ---------------------------------------------------------------------------
module tb_branch_pred_gshare;

    logic clk;
    logic rst;

    // gshare instance signals
    logic [31:0] g_pc;
    logic        g_branch;
    logic [15:0] g_offset;
    logic        g_pred_taken;
    logic [31:0] g_pred_addr;
    logic [5:0]  g_pred_idx;
    logic [3:0]  g_pred_ghr;
    logic        g_upd_valid;
    logic        g_upd_taken;
    logic [5:0]  g_upd_idx;
    logic [3:0]  g_upd_ghr;
    logic        g_upd_mispredict;

    // bimodal instance signals
    logic [31:0] b_pc;
    logic        b_branch;
    logic [15:0] b_offset;
    logic        b_pred_taken;
    logic [31:0] b_pred_addr;
    logic [5:0]  b_pred_idx;
    logic [0:0]  b_pred_ghr;
    logic        b_upd_valid;
    logic        b_upd_taken;
    logic [5:0]  b_upd_idx;
    logic [0:0]  b_upd_ghr;
    logic        b_upd_mispredict;

    int checks;
    int failures;

    branch_pred_gshare #(
        .IDX_BITS(6), .GHR_BITS(4), .PC_LSB(0), .CTR_INIT(2'd2)
    ) dut (
        .clk(clk), .rst(rst),
        .pc_1(g_pc), .branch(g_branch), .offset(g_offset),
        .pred_taken(g_pred_taken), .pred_addr(g_pred_addr),
        .pred_idx(g_pred_idx), .pred_ghr(g_pred_ghr),
        .upd_valid(g_upd_valid), .upd_taken(g_upd_taken),
        .upd_idx(g_upd_idx), .upd_ghr(g_upd_ghr),
        .upd_mispredict(g_upd_mispredict)
    );

    branch_pred_gshare #(
        .IDX_BITS(6), .GHR_BITS(0), .PC_LSB(0), .CTR_INIT(2'd2)
    ) dut_bi (
        .clk(clk), .rst(rst),
        .pc_1(b_pc), .branch(b_branch), .offset(b_offset),
        .pred_taken(b_pred_taken), .pred_addr(b_pred_addr),
        .pred_idx(b_pred_idx), .pred_ghr(b_pred_ghr),
        .upd_valid(b_upd_valid), .upd_taken(b_upd_taken),
        .upd_idx(b_upd_idx), .upd_ghr(b_upd_ghr),
        .upd_mispredict(b_upd_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    int g_ctr [64];
    int b_ctr [64];
    int g_ghr;

    function automatic int sat_step(input int c, input bit taken);
        if (taken) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int g_idx_m();
        return int'(g_pc[5:0]) ^ g_ghr;
    endfunction

    function automatic bit g_pred_m();
        return g_branch && (g_ctr[g_idx_m()] >= 2);
    endfunction

    function automatic bit b_pred_m();
        return b_branch && (b_ctr[int'(b_pc[5:0])] >= 2);
    endfunction

    function automatic logic [31:0] target_m(input logic [31:0] pc, input logic [15:0] off);
        longint soff;
        soff = off[15] ? longint'(off) - 65536 : longint'(off);
        return 32'(longint'(pc) + soff);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                g_ctr[i] <= 2;
                b_ctr[i] <= 2;
            end
            g_ghr <= 0;
        end else begin
            if (g_upd_valid)
                g_ctr[g_upd_idx] <= sat_step(g_ctr[g_upd_idx], g_upd_taken);
            if (b_upd_valid)
                b_ctr[b_upd_idx] <= sat_step(b_ctr[b_upd_idx], b_upd_taken);
            // History = last four outcomes, newest in the units bit.
            if (g_upd_valid && g_upd_mispredict)
                g_ghr <= (int'(g_upd_ghr) * 2 + int'(g_upd_taken)) % 16;
            else if (g_branch)
                g_ghr <= (g_ghr * 2 + int'(g_pred_m())) % 16;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic idle_inputs();
        g_branch = 1'b0; g_upd_valid = 1'b0; g_upd_mispredict = 1'b0;
        g_upd_taken = 1'b0; g_upd_idx = '0; g_upd_ghr = '0;
        b_branch = 1'b0; b_upd_valid = 1'b0; b_upd_mispredict = 1'b0;
        b_upd_taken = 1'b0; b_upd_idx = '0; b_upd_ghr = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        g_pc = 32'h100; g_branch = 1'b1; g_offset = 16'hFFFC;
        b_pc = 32'h100; b_branch = 1'b1; b_offset = 16'h0004;
        // Training attempts during reset must be ignored.
        g_upd_valid = 1'b1; g_upd_idx = 6'h00; g_upd_taken = 1'b0; g_upd_mispredict = 1'b1;
        b_upd_valid = 1'b1; b_upd_idx = 6'h00; b_upd_taken = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        rst = 1'b0;
        g_upd_valid = 1'b0; b_upd_valid = 1'b0; g_upd_mispredict = 1'b0;
        #1;
        checks++;
        if (g_pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL reset_pred_taken got=%0b want=1", g_pred_taken);
        end
        checks++;
        if (g_pred_ghr !== 4'd0) begin
            failures++;
            $display("FAIL reset_pred_ghr got=%0h want=0", g_pred_ghr);
        end
        checks++;
        if (g_pred_addr !== 32'h0000_00FC) begin
            failures++;
            $display("FAIL reset_pred_addr got=%08h want=000000fc", g_pred_addr);
        end
        checks++;
        if (g_pred_idx !== 6'h00) begin
            failures++;
            $display("FAIL reset_pred_idx got=%0h want=0", g_pred_idx);
        end
        checks++;
        if (b_pred_taken !== 1'b1 || b_pred_addr !== 32'h104) begin
            failures++;
            $display("FAIL reset_bimodal got taken=%0b addr=%08h want taken=1 addr=00000104",
                     b_pred_taken, b_pred_addr);
        end
        // Branch low gates the prediction but not the target.
        g_branch = 1'b0;
        #1;
        checks++;
        if (g_pred_taken !== 1'b0 || g_pred_addr !== 32'h0FC) begin
            failures++;
            $display("FAIL reset_branch_gate got taken=%0b addr=%08h want taken=0 addr=000000fc",
                     g_pred_taken, g_pred_addr);
        end
        $display("test_reset: done");
    endtask

    task automatic test_bimodal();
        bit exp_pred [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        bit outcome  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        idle_inputs();
        @(posedge clk); #1;
        b_pc = 32'h0000_4005; b_branch = 1'b1; b_offset = 16'h0010;
        for (int i = 0; i < 10; i++) begin
            b_upd_valid = 1'b1; b_upd_idx = 6'd5; b_upd_taken = outcome[i];
            b_upd_mispredict = 1'b1;
            next_cycle();
            b_upd_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (b_pred_taken !== exp_pred[i]) begin
                failures++;
                $display("FAIL bimodal_step%0d got=%0b want=%0b", i, b_pred_taken, exp_pred[i]);
            end
            checks++;
            if (b_pred_taken !== b_pred_m()) begin
                failures++;
                $display("FAIL bimodal_model%0d got=%0b want=%0b", i, b_pred_taken, b_pred_m());
            end
            $display("bimodal update %0d taken=%0b -> pred=%0b", i, outcome[i], b_pred_taken);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_gshare();
        // Fresh state: pulse reset between edges.
        @(posedge clk); #1;
        rst = 1'b1; #2; rst = 1'b0;
        idle_inputs();
        g_offset = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            g_pc = 32'h200 + 32'(i * 4); g_branch = 1'b1;
            @(negedge clk);
            checks++;
            if (g_pred_taken !== 1'b1) begin
                failures++;
                $display("FAIL gshare_fetch%0d got=%0b want=1", i, g_pred_taken);
            end
            next_cycle();
        end
        g_branch = 1'b0;
        g_pc = 32'h0000_000A;
        @(negedge clk);
        checks++;
        if (g_pred_ghr !== 4'b0111) begin
            failures++;
            $display("FAIL gshare_ghr got=%0b want=0111", g_pred_ghr);
        end
        checks++;
        if (g_pred_idx !== 6'h0D) begin
            failures++;
            $display("FAIL gshare_idx got=%0h want=0d", g_pred_idx);
        end
        $display("gshare: ghr=%0b idx=%0h", g_pred_ghr, g_pred_idx);
    endtask

    task automatic test_recovery();
        @(posedge clk); #1;
        g_pc = 32'h0000_0031; g_branch = 1'b1;
        g_upd_valid = 1'b1; g_upd_mispredict = 1'b1; g_upd_ghr = 4'b1010;
        g_upd_taken = 1'b0; g_upd_idx = 6'h20;
        @(negedge clk);
        checks++;
        if (g_pred_taken !== g_pred_m()) begin
            failures++;
            $display("FAIL recover_same_cycle_pred got=%0b want=%0b", g_pred_taken, g_pred_m());
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (g_pred_ghr !== 4'b0100) begin
            failures++;
            $display("FAIL recover_ghr got=%0b want=0100", g_pred_ghr);
        end
        $display("recovery: ghr=%0b", g_pred_ghr);
        // Mispredict flag without valid must not repair; the fetch shift applies.
        @(posedge clk); #1;
        g_pc = 32'h0000_0000; g_branch = 1'b1;
        g_upd_valid = 1'b0; g_upd_mispredict = 1'b1; g_upd_ghr = 4'b1111; g_upd_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (g_pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL novalid_pred got=%0b want=1", g_pred_taken);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (g_pred_ghr !== 4'b1001) begin
            failures++;
            $display("FAIL novalid_ghr got=%0b want=1001", g_pred_ghr);
        end
        $display("mispredict without valid: ghr=%0b", g_pred_ghr);
    endtask

    task automatic test_same_index();
        // Bring bimodal counter 3 to 1, then train it taken while fetching it.
        @(posedge clk); #1;
        idle_inputs();
        b_upd_valid = 1'b1; b_upd_idx = 6'd3; b_upd_taken = 1'b0;
        next_cycle();
        b_pc = 32'h0000_0003; b_branch = 1'b1;
        b_upd_valid = 1'b1; b_upd_idx = 6'd3; b_upd_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (b_pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL same_index_old got=%0b want=0", b_pred_taken);
        end
        next_cycle();
        b_upd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL same_index_new got=%0b want=1", b_pred_taken);
        end
        $display("same index: pred now=%0b", b_pred_taken);
        idle_inputs();
    endtask

    task automatic test_random();
        int n_fail_start;
        n_fail_start = failures;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk); #1;
            g_pc = $urandom(); g_branch = 1'($urandom_range(0, 3) != 0);
            g_offset = 16'($urandom());
            g_upd_valid = 1'($urandom_range(0, 1));
            g_upd_taken = 1'($urandom_range(0, 1));
            g_upd_mispredict = 1'($urandom_range(0, 3) == 0);
            g_upd_ghr = 4'($urandom());
            // Half the time train the entry being fetched to exercise collisions.
            g_upd_idx = ($urandom_range(0, 1) != 0) ? 6'(g_idx_m()) : 6'($urandom());
            b_pc = $urandom(); b_branch = 1'($urandom_range(0, 1));
            b_offset = 16'($urandom());
            b_upd_valid = 1'($urandom_range(0, 1));
            b_upd_taken = 1'($urandom_range(0, 1));
            b_upd_mispredict = 1'($urandom_range(0, 1));
            b_upd_ghr = 1'($urandom());
            b_upd_idx = ($urandom_range(0, 1) != 0) ? b_pc[5:0] : 6'($urandom());
            @(negedge clk);
            checks++;
            if (g_pred_idx !== 6'(g_idx_m())) begin
                failures++;
                $display("FAIL rand_idx t=%0d got=%0h want=%0h", t, g_pred_idx, g_idx_m());
            end
            checks++;
            if (g_pred_taken !== g_pred_m()) begin
                failures++;
                $display("FAIL rand_taken t=%0d got=%0b want=%0b", t, g_pred_taken, g_pred_m());
            end
            checks++;
            if (g_pred_ghr !== 4'(g_ghr)) begin
                failures++;
                $display("FAIL rand_ghr t=%0d got=%0h want=%0h", t, g_pred_ghr, g_ghr);
            end
            checks++;
            if (g_pred_addr !== target_m(g_pc, g_offset)) begin
                failures++;
                $display("FAIL rand_addr t=%0d got=%08h want=%08h", t, g_pred_addr,
                         target_m(g_pc, g_offset));
            end
            checks++;
            if (b_pred_taken !== b_pred_m() || b_pred_idx !== b_pc[5:0] || b_pred_ghr !== 1'b0) begin
                failures++;
                $display("FAIL rand_bimodal t=%0d got taken=%0b idx=%0h ghr=%0b want taken=%0b idx=%0h ghr=0",
                         t, b_pred_taken, b_pred_idx, b_pred_ghr, b_pred_m(), b_pc[5:0]);
            end
        end
        idle_inputs();
        $display("random: 400 cycles, new failures=%0d", failures - n_fail_start);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        idle_inputs();
        // Drive gshare counter 0x11 and bimodal counter 5 down to 0.
        for (int i = 0; i < 3; i++) begin
            g_upd_valid = 1'b1; g_upd_idx = 6'h11; g_upd_taken = 1'b0;
            b_upd_valid = 1'b1; b_upd_idx = 6'd5;  b_upd_taken = 1'b0;
            next_cycle();
        end
        // Repair the history to a non-zero value.
        g_upd_idx = 6'h30; g_upd_taken = 1'b1; g_upd_mispredict = 1'b1; g_upd_ghr = 4'b0011;
        b_upd_valid = 1'b0;
        next_cycle();
        idle_inputs();
        g_pc = 32'h0000_0011; g_branch = 1'b1;
        b_pc = 32'h0000_0005; b_branch = 1'b1;
        @(negedge clk);
        checks++;
        if (g_pred_ghr !== 4'b0111 || b_pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset got ghr=%0b btaken=%0b want ghr=0111 btaken=0",
                     g_pred_ghr, b_pred_taken);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (g_pred_ghr !== 4'd0 || g_pred_idx !== 6'h11) begin
            failures++;
            $display("FAIL async_ghr got ghr=%0h idx=%0h want ghr=0 idx=11", g_pred_ghr, g_pred_idx);
        end
        checks++;
        if (g_pred_taken !== 1'b1 || b_pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL async_ctr got gtaken=%0b btaken=%0b want 1 1", g_pred_taken, b_pred_taken);
        end
        checks++;
        if (g_pred_taken !== g_pred_m()) begin
            failures++;
            $display("FAIL async_model got=%0b want=%0b", g_pred_taken, g_pred_m());
        end
        $display("async reset: ghr=%0h gtaken=%0b btaken=%0b", g_pred_ghr, g_pred_taken, b_pred_taken);
        #1;
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        g_pc = '0; g_offset = '0; b_pc = '0; b_offset = '0;
        idle_inputs();
        test_reset();
        test_bimodal();
        test_gshare();
        test_recovery();
        test_same_index();
        test_random();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
